dmem_port_arbiter: RTL

//  Shares the single-port data memory between the pipeline memory stage (CPU port) and a debug/loader

---
 rtl/dmem_arb_pkg.sv | 16 +
 rtl/dmem_wait_counter.sv | 32 +++
 rtl/dmem_port_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port arbiter.
// Arbitration state and port-ownership encodings.
package dmem_arb_pkg;

  typedef enum logic [0:0] {
    ARB,
    LOCKED
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_DBG
  } owner_e;

endpackage

// File: rtl/dmem_wait_counter.sv
// Saturating starvation counter for the debug port.
// Counts cycles DBG waits with its request high.
module dmem_wait_counter #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  input  logic i_gnt,
  output logic o_at_max
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] r_cnt;
  logic          w_at_max;

  assign w_at_max = (r_cnt == CW'(MAX_WAIT));
  assign o_at_max = w_at_max;

  // Clear on grant or idle, else count up and saturate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_req || i_gnt) begin
      r_cnt <= '0;
    end else if (!w_at_max) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between CPU and DBG.
// CPU has priority; DBG has a starvation guard and lock.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int AW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [AW-1:0]    cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic             cpu_stall,
  output logic             cpu_rvalid,
  output logic [WIDTH-1:0] cpu_rdata,
  input  logic             dbg_req,
  input  logic             dbg_we,
  input  logic [AW-1:0]    dbg_addr,
  input  logic [WIDTH-1:0] dbg_wdata,
  input  logic             dbg_lock,
  output logic             dbg_gnt,
  output logic             dbg_rvalid,
  output logic [WIDTH-1:0] dbg_rdata,
  output logic [AW-1:0]    mem_a,
  output logic [WIDTH-1:0] mem_wd,
  output logic             mem_we,
  input  logic [WIDTH-1:0] mem_rd
);

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  owner_e     w_own;
  logic       w_at_max;
  logic       w_dbg_gnt;
  logic       r_cpu_rv;
  logic       r_dbg_rv;

  dmem_wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (dbg_req),
    .i_gnt    (w_dbg_gnt),
    .o_at_max (w_at_max)
  );

  // Pick this cycle's owner of the memory port
  always_comb begin
    w_own = OWN_NONE;
    unique case (r_state)
      ARB: begin
        if (dbg_req && (!cpu_req || w_at_max))
          w_own = OWN_DBG;
        else if (cpu_req)
          w_own = OWN_CPU;
      end
      LOCKED: begin
        if (dbg_req)
          w_own = OWN_DBG;
      end
      default: w_own = OWN_NONE;
    endcase
  end

  assign w_dbg_gnt = (w_own == OWN_DBG);
  assign dbg_gnt   = w_dbg_gnt;
  assign cpu_stall = cpu_req && (w_own != OWN_CPU);

  // Lock entry on a locked DBG grant, exit when lock drops
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ARB:     if (w_dbg_gnt && dbg_lock) w_state_nxt = LOCKED;
      LOCKED:  if (!dbg_lock) w_state_nxt = ARB;
      default: w_state_nxt = ARB;
    endcase
  end

  // Arbitration state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ARB;
    else        r_state <= w_state_nxt;
  end

  // Route the winner onto the memory port
  always_comb begin
    mem_a  = cpu_addr;
    mem_wd = cpu_wdata;
    mem_we = 1'b0;
    unique case (w_own)
      OWN_CPU: mem_we = cpu_we;
      OWN_DBG: begin
        mem_a  = dbg_addr;
        mem_wd = dbg_wdata;
        mem_we = dbg_we;
      end
      default: mem_we = 1'b0;
    endcase
  end

  // Remember who issued a read so data returns to them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpu_rv <= 1'b0;
      r_dbg_rv <= 1'b0;
    end else begin
      r_cpu_rv <= (w_own == OWN_CPU) && !cpu_we;
      r_dbg_rv <= (w_own == OWN_DBG) && !dbg_we;
    end
  end

  assign cpu_rvalid = r_cpu_rv;
  assign dbg_rvalid = r_dbg_rv;
  assign cpu_rdata  = mem_rd;
  assign dbg_rdata  = mem_rd;

endmodule
